// File: rtl/ahb_sram_bridge.sv
// AHB-Lite slave that maps bus transfers onto per-lane strobes of a two-bank, 4-lane SRAM array.
// Define AHB_SRAM_BRIDGE_ERR_EN to answer illegal transfers with a two-cycle ERROR response.
module ahb_sram_bridge #(
   parameter int SRAM_AW = 13
) (
   input  logic               hclk,
   input  logic               hresetn,
   input  logic               hsel,
   input  logic               hready,
   input  logic [1:0]         htrans,
   input  logic               hwrite,
   input  logic [2:0]         hsize,
   input  logic [31:0]        haddr,
   input  logic [31:0]        hwdata,
   output logic               hreadyout,
   output logic [1:0]         hresp,
   output logic [31:0]        hrdata,
   input  logic               bist_en,
   input  logic [7:0]         sram_q0,
   input  logic [7:0]         sram_q1,
   input  logic [7:0]         sram_q2,
   input  logic [7:0]         sram_q3,
   input  logic [7:0]         sram_q4,
   input  logic [7:0]         sram_q5,
   input  logic [7:0]         sram_q6,
   input  logic [7:0]         sram_q7,
   output logic               sram_wen,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic [31:0]        sram_wdata,
   output logic [3:0]         bank0_csn,
   output logic [3:0]         bank1_csn
);

   typedef enum logic [2:0] {
      IDLE, WR, RD, RD_PEND
`ifdef AHB_SRAM_BRIDGE_ERR_EN
      , ERR1, ERR2
`endif
   } state_t;

   state_t state_reg, state_next;

   logic               stall;
   logic               xfer_valid, xfer_bad, wr_xfer, rd_xfer;
   logic [3:0]         byte_lane, half_lane, lanes;
   logic [SRAM_AW-1:0] haddr_word;
   logic               haddr_bank;
   logic [31:0]        bank0_q, bank1_q;

   logic [SRAM_AW-1:0] wr_addr_reg, pend_addr_reg, addr_hold_reg;
   logic [3:0]         wr_lanes_reg;
   logic               wr_bank_reg, pend_bank_reg, rd_bank_reg;
   logic [31:0]        wdata_hold_reg;
   logic               unused_ok;

   assign unused_ok  = ^{haddr[31:SRAM_AW+3], htrans[0]};
   assign haddr_word = haddr[SRAM_AW+1:2];
   assign haddr_bank = haddr[SRAM_AW+2];
   assign bank0_q    = {sram_q3, sram_q2, sram_q1, sram_q0};
   assign bank1_q    = {sram_q7, sram_q6, sram_q5, sram_q4};

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign byte_lane[gi] = (haddr[1:0] == 2'(gi));
         assign half_lane[gi] = (haddr[1] == (gi >= 2));
      end
   endgenerate

   always_comb begin
      lanes = 4'b0000;
      case (hsize)
         3'd0:    lanes = byte_lane;
         3'd1:    lanes = half_lane;
         3'd2:    lanes = 4'b1111;
         default: lanes = 4'b0000;
      endcase
   end

`ifdef AHB_SRAM_BRIDGE_ERR_EN
   assign stall = (state_reg == RD_PEND) || (state_reg == ERR1);
   assign hresp = ((state_reg == ERR1) || (state_reg == ERR2)) ? 2'b01 : 2'b00;
`else
   assign stall = (state_reg == RD_PEND);
   assign hresp = 2'b00;
`endif
   assign hreadyout = ~stall;

   // Our own stall cycles never accept an address phase, whatever hready says.
   assign xfer_valid = hsel & hready & htrans[1] & ~stall;
   assign xfer_bad   = xfer_valid & ((hsize > 3'd2) |
                                     ((hsize == 3'd1) & haddr[0]) |
                                     ((hsize == 3'd2) & (haddr[1:0] != 2'b00)) |
                                     bist_en);
   assign wr_xfer    = xfer_valid & ~xfer_bad & hwrite;
   assign rd_xfer    = xfer_valid & ~xfer_bad & ~hwrite;

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) state_reg <= IDLE;
      else          state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         RD_PEND: state_next = RD;
`ifdef AHB_SRAM_BRIDGE_ERR_EN
         ERR1:    state_next = ERR2;
`endif
         default: begin
            if (xfer_bad)
`ifdef AHB_SRAM_BRIDGE_ERR_EN
               state_next = ERR1;
`else
               state_next = IDLE;
`endif
            else if (wr_xfer)
               state_next = WR;
            else if (rd_xfer)
               state_next = (state_reg == WR) ? RD_PEND : RD;
            else
               state_next = IDLE;
         end
      endcase
   end

   always_comb begin
      hrdata     = 32'h0;
      sram_wen   = 1'b1;
      sram_addr  = addr_hold_reg;
      sram_wdata = wdata_hold_reg;
      bank0_csn  = 4'hF;
      bank1_csn  = 4'hF;
      case (state_reg)
         WR: begin
            sram_wen   = 1'b0;
            sram_addr  = wr_addr_reg;
            sram_wdata = hwdata;
            if (wr_bank_reg) bank1_csn = ~wr_lanes_reg;
            else             bank0_csn = ~wr_lanes_reg;
         end
         RD_PEND: begin
            sram_addr = pend_addr_reg;
            if (pend_bank_reg) bank1_csn = 4'h0;
            else               bank0_csn = 4'h0;
         end
         RD:      hrdata = rd_bank_reg ? bank1_q : bank0_q;
         default: ;
      endcase
      // A read address phase owns the port unless a write data phase is using it.
      if (rd_xfer && (state_reg != WR)) begin
         sram_addr = haddr_word;
         if (haddr_bank) bank1_csn = 4'h0;
         else            bank0_csn = 4'h0;
      end
      if (!hresetn) begin
         sram_wen   = 1'b1;
         sram_addr  = addr_hold_reg;
         sram_wdata = wdata_hold_reg;
         bank0_csn  = 4'hF;
         bank1_csn  = 4'hF;
      end
   end

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         wr_addr_reg    <= '0;
         wr_bank_reg    <= 1'b0;
         wr_lanes_reg   <= 4'h0;
         pend_addr_reg  <= '0;
         pend_bank_reg  <= 1'b0;
         rd_bank_reg    <= 1'b0;
         addr_hold_reg  <= '0;
         wdata_hold_reg <= 32'h0;
      end else begin
         addr_hold_reg  <= sram_addr;
         wdata_hold_reg <= sram_wdata;
         if (wr_xfer) begin
            wr_addr_reg  <= haddr_word;
            wr_bank_reg  <= haddr_bank;
            wr_lanes_reg <= lanes;
         end
         if (rd_xfer) begin
            if (state_reg == WR) begin
               pend_addr_reg <= haddr_word;
               pend_bank_reg <= haddr_bank;
            end else begin
               rd_bank_reg <= haddr_bank;
            end
         end else if (state_reg == RD_PEND) begin
            rd_bank_reg <= pend_bank_reg;
         end
      end
   end

endmodule
